// File: rtl/piso_tx_scheduler.sv
// rtl/piso_tx_scheduler.sv - round-robin scheduler sharing one PISO shift register between requesters
// Launches a new word on idle or on the last serial bit, so consecutive frames stream without gaps.
module piso_tx_scheduler #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    piso_load,
  output logic [WIDTH-1:0]        piso_d,
  output logic                    ser_valid,
  output logic                    ser_first,
  output logic                    ser_last,
  output logic [IDW-1:0]          grant_id,
  output logic                    busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [IDW-1:0]  ptr, ptr_next;
  logic [IDW-1:0]  gid_next;
  logic            valid_next, first_next, last_next;

  logic [IDW-1:0]  win;
  logic            found;
  logic            launch;

  // Search starts just past the last winner so every requester gets its turn.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      logic [IDW-1:0] cand;
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign launch = reset && found && ((state == IDLE) || (cnt == CW'(1)));

  always_comb begin
    req_ready = '0;
    piso_load = 1'b0;
    piso_d    = '0;
    if (launch) begin
      req_ready[win] = 1'b1;
      piso_load      = 1'b1;
      piso_d         = req_data[int'(win)*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ptr_next   = ptr;
    gid_next   = grant_id;
    valid_next = ser_valid;
    first_next = ser_first;
    last_next  = ser_last;
    if (launch) begin
      state_next = SHIFT;
      cnt_next   = CW'(WIDTH);
      ptr_next   = win;
      gid_next   = win;
      valid_next = 1'b1;
      first_next = 1'b1;
      last_next  = (WIDTH == 1);
    end else if (state == SHIFT) begin
      if (cnt == CW'(1)) begin
        state_next = IDLE;
        cnt_next   = '0;
        valid_next = 1'b0;
        first_next = 1'b0;
        last_next  = 1'b0;
      end else begin
        cnt_next   = cnt - CW'(1);
        first_next = 1'b0;
        last_next  = (cnt == CW'(2));
      end
    end
  end

  // Pointer parks on the highest index so requester 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= IDW'(NREQ - 1);
      grant_id  <= '0;
      ser_valid <= 1'b0;
      ser_first <= 1'b0;
      ser_last  <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      ptr       <= ptr_next;
      grant_id  <= gid_next;
      ser_valid <= valid_next;
      ser_first <= first_next;
      ser_last  <= last_next;
    end
  end

  assign busy = ser_valid;

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// tb/tb_piso_tx_scheduler.sv - scoreboard bench for piso_tx_scheduler driving a behavioural PISO
module tb_piso_tx_scheduler;

  localparam int WIDTH = 4;
  localparam int NREQ  = 2;
  localparam int IDW   = 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  piso_load;
  logic [WIDTH-1:0]      piso_d;
  logic                  ser_valid, ser_first, ser_last, busy;
  logic [IDW-1:0]        grant_id;
  logic [WIDTH-1:0]      sr;
  logic                  q;

  always #5 clk = ~clk;

  piso_tx_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .piso_load(piso_load), .piso_d(piso_d),
    .ser_valid(ser_valid), .ser_first(ser_first), .ser_last(ser_last),
    .grant_id(grant_id), .busy(busy)
  );

  always @(posedge clk) begin
    if (piso_load) sr <= piso_d;
    else           sr <= sr << 1;
  end
  assign q = sr[WIDTH-1];

  typedef struct packed {
    logic           q;
    logic           first;
    logic           last;
    logic [IDW-1:0] id;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [WIDTH-1:0] w, input logic [IDW-1:0] id, input int nbits);
    exp_t e;
    for (int b = WIDTH - 1; b >= WIDTH - nbits; b--) begin
      e.q     = w[b];
      e.first = (b == WIDTH - 1);
      e.last  = (b == 0);
      e.id    = id;
      sb.push_back(e);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle that carries a frame bit must match the next scoreboard entry.
  always @(negedge clk) begin
    if (ser_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_bit actual=ser_valid expected=idle at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("q", 32'(q), 32'(e.q));
        chk("ser_first", 32'(ser_first), 32'(e.first));
        chk("ser_last", 32'(ser_last), 32'(e.last));
        chk("grant_id", 32'(grant_id), 32'(e.id));
        chk("busy", 32'(busy), 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ready;
    reset     = 1'b0;
    req_valid = 2'b11;
    req_data  = {4'h5, 4'hA};

    // Reset held for three edges with both requesters pending.
    repeat (3) begin
      next_cycle();
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_load", 32'(piso_load), 0);
      chk("rst_d", 32'(piso_d), 0);
      chk("rst_valid", 32'(ser_valid), 0);
      chk("rst_first", 32'(ser_first), 0);
      chk("rst_last", 32'(ser_last), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_gid", 32'(grant_id), 0);
    end
    reset = 1'b1;
    push_frame(4'hA, 1'b0, 4);
    #1;
    chk("rel_ready", 32'(req_ready), 1);
    chk("rel_load", 32'(piso_load), 1);
    chk("rel_d", 32'(piso_d), 32'hA);
    next_cycle();
    req_valid = 2'b00;
    repeat (4) next_cycle();
    @(negedge clk);
    chk("t1_idle", 32'(ser_valid), 0);

    // Single request from requester 1, word 1011.
    next_cycle();
    req_data[7:4] = 4'b1011;
    req_valid     = 2'b10;
    push_frame(4'b1011, 1'b1, 4);
    @(negedge clk);
    chk("t2_ready", 32'(req_ready), 2);
    chk("t2_d", 32'(piso_d), 32'hB);
    next_cycle();
    req_valid = 2'b00;
    repeat (4) next_cycle();
    @(negedge clk);
    chk("t2_idle", 32'(ser_valid), 0);
    chk("t2_idle_d", 32'(piso_d), 0);

    // Both valid: gapless alternating frames A,5,A,5.
    next_cycle();
    req_data  = {4'h5, 4'hA};
    req_valid = 2'b11;
    push_frame(4'hA, 1'b0, 4);
    push_frame(4'h5, 1'b1, 4);
    push_frame(4'hA, 1'b0, 4);
    push_frame(4'h5, 1'b1, 4);
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      exp_ready = (i % 4 == 0 && i <= 12) ? (((i / 4) % 2 == 0) ? 1 : 2) : 0;
      chk("t3_ready", 32'(req_ready), 32'(exp_ready));
      chk("t3_valid", 32'(ser_valid), (i >= 1) ? 1 : 0);
      next_cycle();
      if (i == 12) req_valid = 2'b00;
    end
    @(negedge clk);
    chk("t3_idle", 32'(ser_valid), 0);

    // Requester 0 arrives during the second bit of requester 1's frame.
    next_cycle();
    req_data[7:4] = 4'h3;
    req_valid     = 2'b10;
    push_frame(4'h3, 1'b1, 4);
    push_frame(4'hC, 1'b0, 4);
    for (int i = 0; i <= 9; i++) begin
      if (i == 1) req_valid = 2'b00;
      if (i == 2) begin
        req_data[3:0] = 4'hC;
        req_valid     = 2'b01;
      end
      if (i == 5) req_valid = 2'b00;
      @(negedge clk);
      exp_ready = (i == 0) ? 2 : (i == 4) ? 1 : 0;
      chk("t4_ready", 32'(req_ready), 32'(exp_ready));
      chk("t4_load", 32'(piso_load), (exp_ready != 0) ? 1 : 0);
      chk("t4_valid", 32'(ser_valid), (i >= 1 && i <= 8) ? 1 : 0);
      next_cycle();
    end

    // Reset lands on the third bit of requester 0's frame (word 1001).
    req_data[3:0] = 4'h9;
    req_valid     = 2'b01;
    push_frame(4'h9, 1'b0, 3);
    for (int i = 0; i <= 6; i++) begin
      if (i == 1) req_valid = 2'b00;
      if (i == 3) reset = 1'b0;
      if (i == 5) reset = 1'b1;
      @(negedge clk);
      chk("t5_ready", 32'(req_ready), (i == 0) ? 1 : 0);
      chk("t5_load", 32'(piso_load), (i == 0) ? 1 : 0);
      chk("t5_valid", 32'(ser_valid), (i >= 1 && i <= 3) ? 1 : 0);
      chk("t5_busy", 32'(busy), (i >= 1 && i <= 3) ? 1 : 0);
      next_cycle();
    end

    // Requester 1 withdraws before its turn; requester 0 keeps getting grants.
    req_data  = {4'h9, 4'h6};
    req_valid = 2'b11;
    push_frame(4'h6, 1'b0, 4);
    push_frame(4'h6, 1'b0, 4);
    push_frame(4'h6, 1'b0, 4);
    for (int j = 0; j <= 13; j++) begin
      if (j == 1) req_valid = 2'b01;
      if (j == 9) req_valid = 2'b00;
      @(negedge clk);
      exp_ready = (j == 0 || j == 4 || j == 8) ? 1 : 0;
      chk("t6_ready", 32'(req_ready), 32'(exp_ready));
      chk("t6_valid", 32'(ser_valid), (j >= 1 && j <= 12) ? 1 : 0);
      next_cycle();
    end

    chk("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
